systolic_array_ctrl: RTL and testbench

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

---
 rtl/systolic_pkg.sv | 15 +
 rtl/systolic_skew_shreg.sv | 31 +++
 rtl/systolic_array_ctrl.sv | 153 +++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array controller: FSM state encoding and
// the width of the activation-vector counter.
package systolic_pkg;

    localparam int VEC_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/systolic_skew_shreg.sv
// Fixed-depth clearable shift register; used for the per-row activation
// skew and the per-column result-valid delay.
module systolic_skew_shreg #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sr_q <= '0;
                else      sr_q[0] <= d_i;
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sr_q <= '0;
                else      sr_q <= {sr_q[DEPTH-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Systolic array controller: weight preload, skewed activation streaming and
// result-valid tracking. SYS_ARRAY_CTRL_PERF_CNT_EN adds busy/bubble counters.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int  PE_ARRAY_W    = 64,
    parameter int  PE_ARRAY_H    = 64,
    parameter int  IN_DATA_WIDTH = 8,
    parameter int  ARRAY_LAT     = 1,
    localparam int ID_W          = (PE_ARRAY_H > 1) ? $clog2(PE_ARRAY_H) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_start,
    input  logic [VEC_CNT_W-1:0]                       i_num_vec,
    output logic                                       o_busy,
    output logic                                       o_done,
    input  logic                                       i_w_vld,
    output logic                                       o_w_rdy,
    input  logic [PE_ARRAY_W-1:0][IN_DATA_WIDTH-1:0]   i_w_data,
    input  logic                                       i_a_vld,
    output logic                                       o_a_rdy,
    input  logic [PE_ARRAY_H-1:0][IN_DATA_WIDTH-1:0]   i_a_data,
    output logic [PE_ARRAY_W-1:0]                      o_load_vld,
    output logic [PE_ARRAY_W-1:0][ID_W-1:0]            o_load_id,
    output logic [PE_ARRAY_W-1:0][IN_DATA_WIDTH-1:0]   o_load_data,
    output logic [PE_ARRAY_H-1:0][IN_DATA_WIDTH-1:0]   o_left_data,
    output logic [PE_ARRAY_W-1:0][IN_DATA_WIDTH-1:0]   o_up_data,
`ifdef SYS_ARRAY_CTRL_PERF_CNT_EN
    output logic [31:0]                                o_cyc_cnt,
    output logic [31:0]                                o_bubble_cnt,
`endif
    output logic [PE_ARRAY_W-1:0]                      o_res_vld
);

    // Last column sees the last vector's valid this many cycles after acceptance.
    localparam int MAX_LAT = ARRAY_LAT * (PE_ARRAY_H + PE_ARRAY_W - 1) + 1;
    localparam int DRN_W   = $clog2(MAX_LAT + 1);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      row_q, row_d;
    logic [VEC_CNT_W-1:0] vec_q, vec_d, num_q, num_d;
    logic [DRN_W-1:0]     drn_q, drn_d;
    logic                 w_acc, a_acc;
    logic [PE_ARRAY_H-1:0][IN_DATA_WIDTH-1:0] a_in;

    assign w_acc = i_w_vld && (state_q == LOAD);
    assign a_acc = i_a_vld && (state_q == STREAM);

    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_w_rdy   = (state_q == LOAD);
    assign o_a_rdy   = (state_q == STREAM);
    assign o_up_data = '0;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        vec_d   = vec_q;
        num_d   = num_q;
        drn_d   = drn_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = LOAD;
                num_d   = i_num_vec;
                row_d   = '0;
                vec_d   = '0;
            end
            LOAD: if (w_acc) begin
                if (row_q == ID_W'(PE_ARRAY_H - 1))
                    state_d = (num_q == '0) ? DONE : STREAM;
                else
                    row_d = row_q + ID_W'(1);
            end
            STREAM: if (a_acc) begin
                vec_d = vec_q + VEC_CNT_W'(1);
                if (vec_q == num_q - VEC_CNT_W'(1)) begin
                    state_d = DRAIN;
                    drn_d   = DRN_W'(MAX_LAT - 1);
                end
            end
            DRAIN: begin
                if (drn_q == '0) state_d = DONE;
                else             drn_d   = drn_q - DRN_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            vec_q       <= '0;
            num_q       <= '0;
            drn_q       <= '0;
            o_load_vld  <= '0;
            o_load_id   <= '0;
            o_load_data <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            vec_q      <= vec_d;
            num_q      <= num_d;
            drn_q      <= drn_d;
            o_load_vld <= {PE_ARRAY_W{w_acc}};
            if (w_acc) begin
                o_load_id   <= {PE_ARRAY_W{row_q}};
                o_load_data <= i_w_data;
            end
        end
    end

    // Anything not accepted enters the skew chains as a zero bubble.
    assign a_in = a_acc ? i_a_data : '0;

    for (genvar r = 0; r < PE_ARRAY_H; r++) begin : g_row
        systolic_skew_shreg #(.DEPTH(r + 1), .WIDTH(IN_DATA_WIDTH)) u_skew (
            .clk (clk),
            .rst (rst),
            .d_i (a_in[r]),
            .q_o (o_left_data[r])
        );
    end

    for (genvar c = 0; c < PE_ARRAY_W; c++) begin : g_col
        systolic_skew_shreg #(.DEPTH(ARRAY_LAT * (PE_ARRAY_H + c) + 1), .WIDTH(1)) u_vld (
            .clk (clk),
            .rst (rst),
            .d_i (a_acc),
            .q_o (o_res_vld[c])
        );
    end

`ifdef SYS_ARRAY_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cyc_cnt    <= '0;
            o_bubble_cnt <= '0;
        end else if (state_q == IDLE && i_start) begin
            o_cyc_cnt    <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (o_busy && o_cyc_cnt != '1)
                o_cyc_cnt <= o_cyc_cnt + 32'd1;
            if (state_q == STREAM && !i_a_vld && o_bubble_cnt != '1)
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed table-driven bench for systolic_array_ctrl at W=H=4, LAT=1.
module tb_systolic_array_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_num_vec = '0;
    logic        o_busy, o_done;
    logic        i_w_vld = 1'b0;
    logic        o_w_rdy;
    logic [31:0] i_w_data = '0;
    logic        i_a_vld = 1'b0;
    logic        o_a_rdy;
    logic [31:0] i_a_data = '0;
    logic [3:0]  o_load_vld;
    logic [7:0]  o_load_id;
    logic [31:0] o_load_data, o_left_data, o_up_data;
    logic [3:0]  o_res_vld;
`ifdef SYS_ARRAY_CTRL_PERF_CNT_EN
    logic [31:0] o_cyc_cnt, o_bubble_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    systolic_array_ctrl #(
        .PE_ARRAY_W(4), .PE_ARRAY_H(4), .IN_DATA_WIDTH(8), .ARRAY_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_vec(i_num_vec),
        .o_busy(o_busy), .o_done(o_done),
        .i_w_vld(i_w_vld), .o_w_rdy(o_w_rdy), .i_w_data(i_w_data),
        .i_a_vld(i_a_vld), .o_a_rdy(o_a_rdy), .i_a_data(i_a_data),
        .o_load_vld(o_load_vld), .o_load_id(o_load_id), .o_load_data(o_load_data),
        .o_left_data(o_left_data), .o_up_data(o_up_data),
`ifdef SYS_ARRAY_CTRL_PERF_CNT_EN
        .o_cyc_cnt(o_cyc_cnt), .o_bubble_cnt(o_bubble_cnt),
`endif
        .o_res_vld(o_res_vld)
    );

    typedef struct {
        logic        st;
        logic [15:0] num;
        logic        wv;
        logic [31:0] wd;
        logic        av;
        logic [31:0] ad;
        logic        busy, wrdy, ardy, done;
        logic [3:0]  lvld;
        logic [1:0]  lid;
        logic [31:0] left;
        logic [3:0]  res;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic st, logic [15:0] num, logic wv, logic [31:0] wd,
                                logic av, logic [31:0] ad, logic busy, logic wrdy,
                                logic ardy, logic done, logic [3:0] lvld, logic [1:0] lid,
                                logic [31:0] left, logic [3:0] res);
        vec_t v;
        v.st = st; v.num = num; v.wv = wv; v.wd = wd; v.av = av; v.ad = ad;
        v.busy = busy; v.wrdy = wrdy; v.ardy = ardy; v.done = done;
        v.lvld = lvld; v.lid = lid; v.left = left; v.res = res;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"},  32'(o_busy), 32'd0);
        chk({tag, " done"},  32'(o_done), 32'd0);
        chk({tag, " wrdy"},  32'(o_w_rdy), 32'd0);
        chk({tag, " ardy"},  32'(o_a_rdy), 32'd0);
        chk({tag, " lvld"},  32'(o_load_vld), 32'd0);
        chk({tag, " lid"},   32'(o_load_id), 32'd0);
        chk({tag, " ldata"}, o_load_data, 32'd0);
        chk({tag, " left"},  o_left_data, 32'd0);
        chk({tag, " up"},    o_up_data, 32'd0);
        chk({tag, " res"},   32'(o_res_vld), 32'd0);
    endtask

    localparam logic [31:0] W0 = 32'h13121110, W1 = 32'h23222120,
                            W2 = 32'h33323130, W3 = 32'h43424140;
    localparam logic [31:0] A0 = 32'h04030201, A1 = 32'h08070605;

    int res_sum;
    int done_seen;

    initial begin
        // Job 1: num=2, one bubble between vectors; start during STREAM and DONE ignored.
        // Job 2: start the cycle after DONE with num=0, LOAD goes straight to DONE.
        tbl[0]  = mk(1, 2, 0, 0,  0, 0,  1, 1, 0, 0, 4'h0, 0, 32'h0, 4'h0);
        tbl[1]  = mk(0, 0, 1, W0, 0, 0,  1, 1, 0, 0, 4'hF, 0, 32'h0, 4'h0);
        tbl[2]  = mk(0, 0, 1, W1, 0, 0,  1, 1, 0, 0, 4'hF, 1, 32'h0, 4'h0);
        tbl[3]  = mk(0, 0, 1, W2, 0, 0,  1, 1, 0, 0, 4'hF, 2, 32'h0, 4'h0);
        tbl[4]  = mk(0, 0, 1, W3, 0, 0,  1, 0, 1, 0, 4'hF, 3, 32'h0, 4'h0);
        tbl[5]  = mk(0, 0, 0, 0,  1, A0, 1, 0, 1, 0, 4'h0, 0, 32'h00000001, 4'h0);
        tbl[6]  = mk(1, 5, 0, 0,  0, 0,  1, 0, 1, 0, 4'h0, 0, 32'h00000200, 4'h0);
        tbl[7]  = mk(0, 0, 0, 0,  1, A1, 1, 0, 0, 0, 4'h0, 0, 32'h00030005, 4'h0);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h04000600, 4'h0);
        tbl[9]  = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h00070000, 4'h1);
        tbl[10] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h08000000, 4'h2);
        tbl[11] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h0, 4'h5);
        tbl[12] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h0, 4'hA);
        tbl[13] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h0, 4'h4);
        tbl[14] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 4'h0, 0, 32'h0, 4'h8);
        tbl[15] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0, 1, 4'h0, 0, 32'h0, 4'h0);
        tbl[16] = mk(1, 3, 0, 0,  0, 0,  0, 0, 0, 0, 4'h0, 0, 32'h0, 4'h0);
        tbl[17] = mk(1, 0, 0, 0,  0, 0,  1, 1, 0, 0, 4'h0, 0, 32'h0, 4'h0);
        tbl[18] = mk(0, 0, 1, W0, 0, 0,  1, 1, 0, 0, 4'hF, 0, 32'h0, 4'h0);
        tbl[19] = mk(0, 0, 1, W1, 0, 0,  1, 1, 0, 0, 4'hF, 1, 32'h0, 4'h0);
        tbl[20] = mk(0, 0, 1, W2, 0, 0,  1, 1, 0, 0, 4'hF, 2, 32'h0, 4'h0);
        tbl[21] = mk(0, 0, 1, W3, 1, A1, 1, 0, 0, 1, 4'hF, 3, 32'h0, 4'h0);
        tbl[22] = mk(0, 0, 0, 0,  1, A0, 0, 0, 0, 0, 4'h0, 0, 32'h0, 4'h0);

        tick();
        tick();
        chk_idle_outputs("in_reset");
        rst = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        for (int i = 0; i < 23; i++) begin
            i_start = tbl[i].st; i_num_vec = tbl[i].num;
            i_w_vld = tbl[i].wv; i_w_data  = tbl[i].wd;
            i_a_vld = tbl[i].av; i_a_data  = tbl[i].ad;
            tick();
            chk($sformatf("v%0d busy", i), 32'(o_busy),     32'(tbl[i].busy));
            chk($sformatf("v%0d wrdy", i), 32'(o_w_rdy),    32'(tbl[i].wrdy));
            chk($sformatf("v%0d ardy", i), 32'(o_a_rdy),    32'(tbl[i].ardy));
            chk($sformatf("v%0d done", i), 32'(o_done),     32'(tbl[i].done));
            chk($sformatf("v%0d lvld", i), 32'(o_load_vld), 32'(tbl[i].lvld));
            chk($sformatf("v%0d left", i), o_left_data,     tbl[i].left);
            chk($sformatf("v%0d res", i),  32'(o_res_vld),  32'(tbl[i].res));
            if (tbl[i].lvld != 4'h0) begin
                chk($sformatf("v%0d lid", i),   32'(o_load_id), 32'({4{tbl[i].lid}}));
                chk($sformatf("v%0d ldata", i), o_load_data,    tbl[i].wd);
            end
`ifdef SYS_ARRAY_CTRL_PERF_CNT_EN
            if (i == 16) begin
                chk("perf cyc", o_cyc_cnt, 32'd16);
                chk("perf bubble", o_bubble_cnt, 32'd1);
            end
`endif
        end
        i_a_vld = 1'b0;

        // Reset mid-STREAM after one of two vectors, then a clean num=1 job.
        i_start = 1'b1; i_num_vec = 16'd2;
        tick();
        i_start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            i_w_vld = 1'b1; i_w_data = W0 + 32'(r);
            tick();
        end
        i_w_vld = 1'b0;
        i_a_vld = 1'b1; i_a_data = A0;
        tick();
        i_a_vld = 1'b0;
        #2 rst = 1'b0;
        #1 chk_idle_outputs("async_rst");
        #2 rst = 1'b1;
        tick();
        chk_idle_outputs("after_rst");

        i_start = 1'b1; i_num_vec = 16'd1;
        tick();
        i_start = 1'b0;
        chk("rerun busy", 32'(o_busy), 32'd1);
        for (int r = 0; r < 4; r++) begin
            i_w_vld = 1'b1; i_w_data = W1;
            tick();
        end
        i_w_vld = 1'b0;
        chk("rerun ardy", 32'(o_a_rdy), 32'd1);
        i_a_vld = 1'b1; i_a_data = A1;
        tick();
        i_a_vld = 1'b0;
        chk("rerun left0", o_left_data, 32'h00000005);
        chk("rerun ardy_drop", 32'(o_a_rdy), 32'd0);
        res_sum = 0;
        done_seen = 0;
        for (int k = 0; k < 40 && done_seen == 0; k++) begin
            res_sum += $countones(o_res_vld);
            if (o_done) done_seen = 1;
            tick();
        end
        chk("rerun done_seen", 32'(done_seen), 32'd1);
        chk("rerun res_pulses", 32'(res_sum), 32'd4);
        chk("rerun idle", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
